// File: rtl/sr_cpu_mc.sv
// Multi-cycle schoolRISCV core: FETCH over a req/valid instruction port, then EXEC.
// Latency: (fetch wait cycles + 1) + 1 per instruction; 2 cycles with zero-wait memory.
// Backpressure: imReq is held with a stable imAddr until imValid; imValid outside FETCH is dropped.
//
// Parameters: RESET_PC (word-aligned reset byte address), CNT_W (counter width 1..32).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imReq, imAddr       fetch request and word address (pc >> 2)
//   imValid, imData     fetch response
//   dbgSel, regAddr     debug select (0 regfile/pc, 1 status, 2 cycle, 3 instret) and reg address
//   regData             combinational debug read data
// Optional feature: define SR_CPU_MC_COUNTERS_EN to build the cycle/instret counters.
module sr_cpu_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imReq,
    output logic [31:0] imAddr,
    input  logic        imValid,
    input  logic [31:0] imData,
    input  logic [1:0]  dbgSel,
    input  logic [4:0]  regAddr,
    output logic [31:0] regData
);

    typedef enum logic {FETCH, EXEC} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        ov;
    logic        ill;
    logic [31:0] regs [31:0];

    // instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] immI;
    logic [31:0] immU;
    logic [31:0] immB;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign immI   = {{20{ir[31]}}, ir[31:20]};
    assign immU   = {ir[31:12], 12'b0};
    assign immB   = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};

    logic [31:0] rs1Val;
    logic [31:0] rs2Val;
    assign rs1Val = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
    assign rs2Val = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

    // decode + ALU
    logic [31:0] aluRes;
    logic [31:0] sumR;
    logic [31:0] sumI;
    logic [31:0] diff;
    logic        wrEn;
    logic        legal;
    logic        ovf;
    logic        branchTaken;
    logic [31:0] pcNext;

    assign sumR = rs1Val + rs2Val;
    assign sumI = rs1Val + immI;
    assign diff = rs1Val - rs2Val;

    always_comb begin
        aluRes      = 32'h0;
        wrEn        = 1'b0;
        legal       = 1'b0;
        ovf         = 1'b0;
        branchTaken = 1'b0;
        case (opcode)
            7'b0110011: begin
                case ({funct7, funct3})
                    10'b0000000_000: begin  // add
                        aluRes = sumR; wrEn = 1'b1; legal = 1'b1;
                        ovf = (rs1Val[31] == rs2Val[31]) && (sumR[31] != rs1Val[31]);
                    end
                    10'b0100000_000: begin  // sub
                        aluRes = diff; wrEn = 1'b1; legal = 1'b1;
                        ovf = (rs1Val[31] != rs2Val[31]) && (diff[31] != rs1Val[31]);
                    end
                    10'b0000000_110: begin  // or
                        aluRes = rs1Val | rs2Val; wrEn = 1'b1; legal = 1'b1;
                    end
                    10'b0000000_101: begin  // srl
                        aluRes = rs1Val >> rs2Val[4:0]; wrEn = 1'b1; legal = 1'b1;
                    end
                    10'b0000000_011: begin  // sltu
                        aluRes = {31'b0, rs1Val < rs2Val}; wrEn = 1'b1; legal = 1'b1;
                    end
                    default: ;
                endcase
            end
            7'b0010011: begin
                if (funct3 == 3'b000) begin  // addi
                    aluRes = sumI; wrEn = 1'b1; legal = 1'b1;
                    ovf = (rs1Val[31] == immI[31]) && (sumI[31] != rs1Val[31]);
                end
            end
            7'b0110111: begin  // lui
                aluRes = immU; wrEn = 1'b1; legal = 1'b1;
            end
            7'b1100011: begin
                if (funct3 == 3'b000) begin  // beq
                    legal = 1'b1; branchTaken = (rs1Val == rs2Val);
                end else if (funct3 == 3'b001) begin  // bne
                    legal = 1'b1; branchTaken = (rs1Val != rs2Val);
                end
            end
            default: ;
        endcase
    end

    assign pcNext = branchTaken ? (pc + immB) : (pc + 32'd4);
    assign imAddr = {2'b00, pc[31:2]};

    // fetch/execute FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= 32'h0000_0013;
            ov    <= 1'b0;
            ill   <= 1'b0;
            imReq <= 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    if (imValid) begin
                        ir    <= imData;
                        state <= EXEC;
                        imReq <= 1'b0;
                    end
                end
                EXEC: begin
                    pc    <= pcNext;
                    state <= FETCH;
                    imReq <= 1'b1;
                    if (ovf)    ov  <= 1'b1;
                    if (!legal) ill <= 1'b1;
                end
                default: state <= FETCH;
            endcase
        end
    end

    // register file: x0 is never written, reads of x0 are forced to zero above
    always_ff @(posedge clk) begin
        if (!rst && state == EXEC && wrEn && rd != 5'd0)
            regs[rd] <= aluRes;
    end

    logic [31:0] cycleDbg;
    logic [31:0] instretDbg;

`ifdef SR_CPU_MC_COUNTERS_EN
    logic [CNT_W-1:0] cycleCnt;
    logic [CNT_W-1:0] instretCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycleCnt   <= '0;
            instretCnt <= '0;
        end else begin
            cycleCnt <= cycleCnt + 1'b1;
            if (state == EXEC)
                instretCnt <= instretCnt + 1'b1;
        end
    end

    assign cycleDbg   = 32'(cycleCnt);
    assign instretDbg = 32'(instretCnt);
`else
    logic unusedCntW;
    assign unusedCntW = (CNT_W > 0);
    assign cycleDbg   = 32'h0;
    assign instretDbg = 32'h0;
`endif

    always_comb begin
        regData = 32'h0;
        case (dbgSel)
            2'd0:    regData = (regAddr == 5'd0) ? pc : regs[regAddr];
            2'd1:    regData = {30'b0, ill, ov};
            2'd2:    regData = cycleDbg;
            default: regData = instretDbg;
        endcase
    end

endmodule

// File: tb/tb_sr_cpu_mc.sv
`timescale 1ns/1ns
module tb_sr_cpu_mc;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          CNT_W    = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imReq;
    logic [31:0] imAddr;
    logic        imValid = 1'b0;
    logic [31:0] imData  = 32'h0;
    logic [1:0]  dbgSel  = 2'd0;
    logic [4:0]  regAddr = 5'd0;
    logic [31:0] regData;

    sr_cpu_mc #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .imReq(imReq), .imAddr(imAddr),
        .imValid(imValid), .imData(imData),
        .dbgSel(dbgSel), .regAddr(regAddr), .regData(regData)
    );

    always #50 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ISA-level model state
    logic [31:0] mRegs [32];
    bit          mKnown [32];
    logic [31:0] mPc;
    bit          mOv, mIll;
    logic [31:0] mInstret;
    logic [31:0] mCycle;

    // cycles elapsed since the last reset edge
    always @(posedge clk) begin
        if (rst) mCycle <= 32'd0;
        else     mCycle <= mCycle + 32'd1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic dbgRead(input logic [1:0] sel, input logic [4:0] addr, output logic [31:0] val);
        dbgSel  = sel;
        regAddr = addr;
        #1;
        val = regData;
    endtask

    function automatic logic [31:0] cntExp(input logic [31:0] v);
        logic [31:0] mask;
        mask = (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);
`ifdef SR_CPU_MC_COUNTERS_EN
        return v & mask;
`else
        return 32'h0 & mask & v;
`endif
    endfunction

    task automatic checkState();
        logic [31:0] v;
        dbgRead(2'd0, 5'd0, v); chk("pc", v, mPc);
        for (int r = 1; r < 32; r++) begin
            if (mKnown[r]) begin
                dbgRead(2'd0, 5'(r), v);
                chk($sformatf("x%0d", r), v, mRegs[r]);
            end
        end
        dbgRead(2'd1, 5'd0, v); chk("status", v, {30'b0, mIll, mOv});
        dbgRead(2'd2, 5'd0, v); chk("cycle", v, cntExp(mCycle));
        dbgRead(2'd3, 5'd0, v); chk("instret", v, cntExp(mInstret));
    endtask

    // encoders
    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] encI(input int imm, input logic [4:0] rs1, input logic [4:0] rd);
        logic [11:0] i;
        i = 12'(imm);
        return {i, rs1, 3'b000, rd, 7'h13};
    endfunction
    function automatic logic [31:0] encU(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'h37};
    endfunction
    function automatic logic [31:0] encB(input int imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        logic [12:0] i;
        i = 13'(imm);
        return {i[12], i[10:5], rs2, rs1, f3, i[4:1], i[11], 7'h63};
    endfunction

    // Reference semantics of one retired instruction
    task automatic execModel(input logic [31:0] ins);
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] a, b, val, immI, immB;
        longint      s, lim;
        bit          legal, wr, take;
        op = ins[6:0]; f7 = ins[31:25]; f3 = ins[14:12];
        rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
        a = (rs1 == 0) ? 32'h0 : mRegs[rs1];
        b = (rs2 == 0) ? 32'h0 : mRegs[rs2];
        immI = {{20{ins[31]}}, ins[31:20]};
        immB = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        lim = 64'sh7FFF_FFFF;
        legal = 1; wr = 0; take = 0; val = 0; s = 0;
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) begin
            val = a + b; wr = 1; s = longint'($signed(a)) + longint'($signed(b));
            if (s > lim || s < -lim - 1) mOv = 1;
        end else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
            val = a - b; wr = 1; s = longint'($signed(a)) - longint'($signed(b));
            if (s > lim || s < -lim - 1) mOv = 1;
        end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd6) begin
            val = a | b; wr = 1;
        end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd5) begin
            val = a >> b[4:0]; wr = 1;
        end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd3) begin
            val = (a < b) ? 32'd1 : 32'd0; wr = 1;
        end else if (op == 7'h13 && f3 == 3'd0) begin
            val = a + immI; wr = 1; s = longint'($signed(a)) + longint'($signed(immI));
            if (s > lim || s < -lim - 1) mOv = 1;
        end else if (op == 7'h37) begin
            val = {ins[31:12], 12'b0}; wr = 1;
        end else if (op == 7'h63 && f3 == 3'd0) begin
            take = (a == b);
        end else if (op == 7'h63 && f3 == 3'd1) begin
            take = (a != b);
        end else begin
            legal = 0;
        end
        if (!legal) mIll = 1;
        if (wr && rd != 0) begin
            mRegs[rd] = val; mKnown[rd] = 1;
        end
        mPc = take ? mPc + immB : mPc + 32'd4;
        mInstret = mInstret + 32'd1;
    endtask

    function automatic logic [31:0] mReg(input int r);
        return mRegs[r];
    endfunction

    // Called shortly after a clock edge with the core in FETCH.
    task automatic runInstr(input logic [31:0] ins, input int waits);
        logic [31:0] v;
        for (int w = 0; w < waits; w++) begin
            imValid = 1'b0;
            #1;
            chk("imReq stall", 32'(imReq), 32'd1);
            chk("imAddr stall", imAddr, mPc >> 2);
            @(posedge clk); #1;
        end
        imValid = 1'b1;
        imData  = ins;
        #1;
        chk("imReq fetch", 32'(imReq), 32'd1);
        chk("imAddr fetch", imAddr, mPc >> 2);
        @(posedge clk); #1;
        // EXEC: a stray response carrying an illegal word must be ignored
        imValid = 1'b1;
        imData  = 32'hFFFF_FFFF;
        #1;
        chk("imReq exec", 32'(imReq), 32'd0);
        dbgRead(2'd0, 5'd0, v); chk("pc during exec", v, mPc);
        @(posedge clk); #1;
        imValid = 1'b0;
        execModel(ins);
        checkState();
    endtask

    task automatic modelReset();
        mPc = RESET_PC; mOv = 0; mIll = 0; mInstret = 32'd0;
    endtask

    task automatic doReset(input int cyc);
        rst = 1'b1; imValid = 1'b0;
        repeat (cyc) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        #1;
        chk("imReq after reset", 32'(imReq), 32'd1);
        checkState();
    endtask

    initial begin
        logic [31:0] v;
        int off;
        for (int r = 0; r < 32; r++) begin mRegs[r] = 32'h0; mKnown[r] = 0; end
        modelReset();

        // A: reset vector and 3 wait cycles
        doReset(2);
        chk("imAddr reset vector", imAddr, 32'h0000_0040);
        runInstr(encI(5, 0, 1), 3);
        dbgRead(2'd2, 5'd0, v); chk("cycle after slow fetch", v, cntExp(32'd5));
        dbgRead(2'd0, 5'd0, v); chk("pc after slow fetch", v, 32'h0000_0104);

        // B: zero-wait program
        doReset(1);
        runInstr(encI(5, 0, 1), 0);
        runInstr(encI(7, 0, 2), 0);
        runInstr(encR(7'h00, 2, 1, 3'd0, 3), 0);
        dbgRead(2'd0, 5'd3, v); chk("x3 literal", v, 32'd12);
        dbgRead(2'd0, 5'd0, v); chk("pc literal", v, 32'h0000_010C);
        dbgRead(2'd3, 5'd0, v); chk("instret literal", v, cntExp(32'd3));
        dbgRead(2'd2, 5'd0, v); chk("cycle literal", v, cntExp(32'd6));

        // C: remaining ALU ops, no overflow
        runInstr(encR(7'h00, 2, 1, 3'd6, 4), 1);   // or   x4 = 5|7
        runInstr(encR(7'h00, 2, 1, 3'd3, 6), 0);   // sltu x6 = 5<7
        runInstr(encR(7'h20, 2, 1, 3'd0, 7), 2);   // sub  x7 = -2
        runInstr(encR(7'h00, 1, 7, 3'd5, 8), 0);   // srl  x8 = 0xFFFFFFFE>>5
        dbgRead(2'd0, 5'd8, v); chk("srl literal", v, 32'h07FF_FFFF);
        dbgRead(2'd1, 5'd0, v); chk("status clean", v, 32'h0);

        // D: overflow and x0
        runInstr(encU(20'h80000, 1), 0);
        runInstr(encI(-1, 0, 2), 0);
        runInstr(encR(7'h00, 2, 1, 3'd0, 3), 0);
        dbgRead(2'd0, 5'd3, v); chk("ov sum literal", v, 32'h7FFF_FFFF);
        dbgRead(2'd1, 5'd0, v); chk("status ov literal", v, 32'h1);
        runInstr(encI(9, 0, 0), 0);
        dbgRead(2'd0, 5'd0, v); chk("x0 reads pc", v, mPc);

        // E: branches around pc 0x20
        off = int'(32'h20 - mPc);
        runInstr(encB(off, 0, 0, 3'd0), 0);        // beq x0,x0 -> 0x20
        dbgRead(2'd0, 5'd0, v); chk("beq target", v, 32'h20);
        runInstr(encB(-8, 2, 1, 3'd1), 0);         // bne taken
        chk("bne taken imAddr", imAddr, 32'd6);
        runInstr(encI(0, 1, 2), 0);                // x2 = x1
        runInstr(encI(0, 0, 0), 0);
        runInstr(encB(-8, 2, 1, 3'd1), 0);         // bne not taken
        chk("bne not taken imAddr", imAddr, 32'd9);

        // F: reset during a stalled fetch with imValid in the reset cycle
        runInstr(encI(1, 0, 9), 0);
        runInstr(encI(3, 0, 10), 0);
        imValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; imValid = 1'b1; imData = encI(99, 0, 9);
        @(posedge clk); #1;
        rst = 1'b0; imValid = 1'b0;
        modelReset();
        #1;
        checkState();
        dbgRead(2'd0, 5'd0, v); chk("pc after fetch reset", v, 32'h100);
        dbgRead(2'd0, 5'd9, v); chk("x9 untouched", v, 32'd1);

        // illegal instructions, then a sub overflow on top
        runInstr(32'hFFFF_FFFF, 1);
        dbgRead(2'd1, 5'd0, v); chk("status ill literal", v, 32'h2);
        dbgRead(2'd3, 5'd0, v); chk("instret ill literal", v, cntExp(32'd1));
        runInstr(encR(7'h01, 2, 1, 3'd0, 11), 0);  // bad funct7
        runInstr(encI(1, 0, 12), 0);
        runInstr(encR(7'h20, 12, 1, 3'd0, 11), 0); // 0x80000000 - 1
        dbgRead(2'd1, 5'd0, v); chk("status both literal", v, 32'h3);

        // G: reset during EXEC aborts the write
        imValid = 1'b1; imData = encI(55, 0, 10);
        @(posedge clk); #1;
        rst = 1'b1; imValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        modelReset();
        #1;
        checkState();
        dbgRead(2'd0, 5'd10, v); chk("x10 untouched", v, 32'd3);
        runInstr(encI(4, 10, 13), 0);
        dbgRead(2'd0, 5'd13, v); chk("x13 after exec reset", v, 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
